shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 161 ++++++++++++++++
 tb/tb_shift_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Serializes a captured 4-bit word LSB-first by sequencing an external 4-bit
// shift register (load / shift-right / hold), with GAP idle cycles between shifts.
module shift_sequencer #(
    parameter int unsigned GAP = 32'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_data,
    input  logic [2:0] req_len,
    input  logic       abort,
    output logic [1:0] sel,
    output logic [3:0] ld_data,
    output logic       bit_valid,
    output logic       done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EMIT = 3'd2,
        S_GAPW = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] GAP_W = 3'(GAP);

    function automatic logic [2:0] eff_len(input logic [2:0] len);
        if ((len == 3'd0) || (len > 3'd4)) begin
            return 3'd4;
        end else begin
            return len;
        end
    endfunction

    state_t     state_r, state_s;
    logic [1:0] k_r, k_s;
    logic [2:0] g_r, g_s;
    logic [3:0] data_r, data_s;
    logic [2:0] len_r, len_s;
    logic [1:0] sel_r, sel_s;
    logic [3:0] ld_data_r, ld_data_s;
    logic       bit_valid_r, bit_valid_s;
    logic       done_r, done_s;
    logic       busy_r, busy_s;
    logic       ready_r, ready_s;
    logic       accept_s;
    logic       last_s;

    assign accept_s = req_valid & ready_r & (state_r == S_IDLE);
    assign last_s   = ({1'b0, k_r} == (len_r - 3'd1));

    // Next-state and transfer bookkeeping.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        g_s     = g_r;
        data_s  = data_r;
        len_s   = len_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_LOAD;
                    data_s  = req_data;
                    len_s   = eff_len(req_len);
                    k_s     = 2'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                k_s     = 2'd0;
                state_s = abort ? S_IDLE : S_EMIT;
            end
            S_EMIT: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (last_s) begin
                    state_s = S_DONE;
                end else begin
                    k_s     = k_r + 2'd1;
                    g_s     = 3'd0;
                    state_s = (GAP_W != 3'd0) ? S_GAPW : S_EMIT;
                end
            end
            S_GAPW: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (g_r == (GAP_W - 3'd1)) begin
                    state_s = S_EMIT;
                end else begin
                    g_s = g_r + 3'd1;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered
    // while still reflecting the current state after each edge.
    always_comb begin
        sel_s       = 2'b00;
        ld_data_s   = 4'd0;
        bit_valid_s = 1'b0;
        done_s      = 1'b0;
        busy_s      = (state_s != S_IDLE);
        ready_s     = (state_s == S_IDLE);
        case (state_s)
            S_LOAD: begin
                sel_s     = 2'b10;
                ld_data_s = data_s;
            end
            S_EMIT: begin
                bit_valid_s = 1'b1;
                sel_s       = ({1'b0, k_s} < (len_s - 3'd1)) ? 2'b01 : 2'b00;
            end
            S_DONE:  done_s = 1'b1;
            default: sel_s  = 2'b00;
        endcase
    end

    // State, counters, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            k_r         <= 2'd0;
            g_r         <= 3'd0;
            data_r      <= 4'd0;
            len_r       <= 3'd0;
            sel_r       <= 2'b00;
            ld_data_r   <= 4'd0;
            bit_valid_r <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            g_r         <= g_s;
            data_r      <= data_s;
            len_r       <= len_s;
            sel_r       <= sel_s;
            ld_data_r   <= ld_data_s;
            bit_valid_r <= bit_valid_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            ready_r     <= ready_s;
        end
    end

    assign req_ready = ready_r & rst_n;
    assign sel       = sel_r;
    assign ld_data   = ld_data_r;
    assign bit_valid = bit_valid_r;
    assign done      = done_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: GAP=0 and GAP=2 sequencers share stimulus; each drives a
// bench-side shift register whose bit 0 is compared against the expected serial stream.
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [3:0] req_data;
    logic [2:0] req_len;
    logic       abort;

    logic       ready0, bv0, done0, busy0;
    logic [1:0] sel0;
    logic [3:0] ld0;
    logic       ready2, bv2, done2, busy2;
    logic [1:0] sel2;
    logic [3:0] ld2;

    logic [3:0] r0, r2;
    int tests = 0;
    int fails = 0;
    int xid   = 0;

    localparam logic [10:0] IDLE_V = 11'b00_0000_00001;

    shift_sequencer #(.GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready0),
        .req_data(req_data), .req_len(req_len), .abort(abort), .sel(sel0),
        .ld_data(ld0), .bit_valid(bv0), .done(done0), .busy(busy0)
    );

    shift_sequencer #(.GAP(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready2),
        .req_data(req_data), .req_len(req_len), .abort(abort), .sel(sel2),
        .ld_data(ld2), .bit_valid(bv2), .done(done2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 4-bit register driven by each sequencer's sel/ld_data.
    always @(posedge clk) begin
        r0 <= (sel0 == 2'b10) ? ld0 : (sel0 == 2'b01) ? {1'b0, r0[3:1]} : r0;
        r2 <= (sel2 == 2'b10) ? ld2 : (sel2 == 2'b01) ? {1'b0, r2[3:1]} : r2;
    end

    wire [10:0] obs0 = {sel0, ld0, bv0, bv0 & r0[0], done0, busy0, ready0};
    wire [10:0] obs2 = {sel2, ld2, bv2, bv2 & r2[0], done2, busy2, ready2};

    // Expected {sel, ld_data, bit_valid, bit, done, busy, req_ready} c cycles after accept.
    function automatic logic [10:0] exp_vec(int c, int g, logic [3:0] d, int L, int ab, int rs);
        int t, p, i;
        t = 2 + L + (L - 1) * g;
        if ((ab > 0 && c >= ab) || (rs >= 0 && c > rs) || c >= t) return IDLE_V;
        if (c == 0) return {2'b10, d, 5'b00010};
        if (c == t - 1) return 11'b00_0000_00110;
        p = c - 1;
        if (p % (g + 1) == 0) begin
            i = p / (g + 1);
            return {(i < L - 1) ? 2'b01 : 2'b00, 4'b0000, 1'b1, d[i], 3'b010};
        end
        return 11'b00_0000_00010;
    endfunction

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s got=%03h exp=%03h", tag, got, expv);
        end
    endtask

    // Runs one request starting just after an edge with both sequencers idle.
    // ab: cycle index at which the sequencers must already be back in IDLE via abort (0 = none).
    // rs: cycle index during which rst_n is pulsed low between edges (-1 = none).
    task automatic xfer(input logic [3:0] d, input logic [2:0] ln, input int ab, input int rs);
        int L, tmax;
        L    = (ln == 3'd0 || ln > 3'd4) ? 4 : int'(ln);
        tmax = 2 + L + (L - 1) * 2;
        xid++;
        req_valid = 1'b1;
        req_data  = d;
        req_len   = ln;
        abort     = 1'($urandom_range(0, 1));
        for (int c = 0; c <= tmax; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("x%0d g0 c%0d", xid, c), obs0, exp_vec(c, 0, d, L, ab, rs));
            chk($sformatf("x%0d g2 c%0d", xid, c), obs2, exp_vec(c, 2, d, L, ab, rs));
            req_valid = (c < 1);
            req_data  = 4'($urandom);
            req_len   = 3'($urandom);
            abort     = (ab > 0) && (c == ab - 1);
            if (c == rs) begin
                #2 rst_n = 1'b0;
                #1;
                chk($sformatf("x%0d rst g0", xid), obs0, 11'd0);
                chk($sformatf("x%0d rst g2", xid), obs2, 11'd0);
                #1 rst_n = 1'b1;
            end
        end
        req_valid = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = 4'd0;
        req_len   = 3'd0;
        abort     = 1'b0;
        #2;
        chk("reset g0", obs0, 11'd0);
        chk("reset g2", obs2, 11'd0);
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset held g0", obs0, 11'd0);
        chk("reset held g2", obs2, 11'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset g0", obs0, IDLE_V);
        chk("post reset g2", obs2, IDLE_V);

        xfer(4'b1011, 3'd4, 0, -1);
        xfer(4'b0110, 3'd3, 0, -1);
        xfer(4'b1001, 3'd0, 0, -1);
        xfer(4'b1001, 3'd7, 0, -1);
        xfer(4'b0001, 3'd1, 0, -1);
        xfer(4'b1101, 3'd4, 3, -1);
        xfer(4'b0111, 3'd2, 0, -1);
        xfer(4'b1010, 3'd3, 0, 2);

        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                chk("idle g0", obs0, IDLE_V);
                chk("idle g2", obs2, IDLE_V);
            end
            xfer(4'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
